// File: rtl/counter_pkg.sv
// Shared types and constants for the BCD modulo counter and its conversion engine.
package counter_pkg;

    // Conversion engine states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } eng_state_t;

    // Direction switch encoding
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Width of one packed BCD digit
    localparam int BCD_DIGIT_W = 4;

endpackage

// File: rtl/bin2bcd_seq.sv
// Multi-cycle double-dabble converter: one add-3/shift step per clock, WIDTH steps
// per conversion, result presented for one cycle in ST_DONE.
module bin2bcd_seq
    import counter_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3
) (
    input  logic                            clk,
    input  logic                            rst_N,
    input  logic                            start,
    input  logic [WIDTH-1:0]                bin_in,
    output logic                            busy,
    output logic                            done,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    eng_state_t        state_reg, state_next;
    logic [SR_W-1:0]   shift_reg, shift_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [BCD_W-1:0]  adj_bcd;
    logic [SR_W-1:0]   sr_adj;

    // Add 3 to every BCD digit that is 5 or more before the next shift
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_add3
            logic [BCD_DIGIT_W-1:0] digit;
            assign digit = shift_reg[WIDTH + gi*BCD_DIGIT_W +: BCD_DIGIT_W];
            assign adj_bcd[gi*BCD_DIGIT_W +: BCD_DIGIT_W] =
                (digit >= 4'd5) ? digit + 4'd3 : digit;
        end
    endgenerate

    assign sr_adj  = {adj_bcd, shift_reg[WIDTH-1:0]};
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_DONE);
    assign bcd_out = shift_reg[SR_W-1 -: BCD_W];

    // State, shift register and step counter
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state and datapath: latch on start, WIDTH shift steps, then one DONE cycle
    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    shift_next = {{BCD_W{1'b0}}, bin_in};
                    cnt_next   = '0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_next = sr_adj << 1;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/bcd_modulo_counter.sv
// Dual-modulus up/down counter with load and wrap flag; keeps a packed BCD copy of
// the count via the sequential converter and tracks whether that copy is current.
module bcd_modulo_counter
    import counter_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 3,
    parameter int MOD_A  = 15,
    parameter int MOD_B  = 115
) (
    input  logic                            clk,
    input  logic                            rst_N,
    input  logic                            tick,
    input  logic                            en_SW,
    input  logic                            modulo_SW,
    input  logic                            dir_SW,
    input  logic                            load,
    input  logic [WIDTH-1:0]                load_value,
    output logic [WIDTH-1:0]                count,
    output logic                            LED,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   number_BCD,
    output logic                            bcd_valid
);

    localparam int    BCD_W   = BCD_DIGIT_W * DIGITS;
    localparam int    MW      = WIDTH + 1;
    localparam longint MOD_MAX = (MOD_A > MOD_B) ? MOD_A : MOD_B;
    localparam logic [MW-1:0] MOD_A_W = MW'(MOD_A);
    localparam logic [MW-1:0] MOD_B_W = MW'(MOD_B);

    // Reject parameter sets whose range does not fit the binary or BCD width
    generate
        if ((MOD_A < 2) || (MOD_B < 2) || ((64'd1 << WIDTH) < MOD_MAX) ||
            ((10 ** DIGITS) < MOD_MAX)) begin : g_bad_params
            $error("bcd_modulo_counter: WIDTH/DIGITS too small for MOD_A/MOD_B, or modulus < 2");
        end
    endgenerate

    logic [WIDTH-1:0] count_reg, count_next;
    logic             led_reg, led_next;
    logic             dirty_reg, dirty_next;
    logic             valid_reg, valid_next;
    logic [BCD_W-1:0] bcd_reg, bcd_next;
    logic [MW-1:0]    m_val, m_last;
    logic [MW-1:0]    count_ext;
    logic             changed;
    logic             eng_start, eng_busy, eng_done;
    logic [BCD_W-1:0] eng_bcd;

    assign m_val     = modulo_SW ? MOD_B_W : MOD_A_W;
    assign m_last    = m_val - MW'(1);
    assign count_ext = {1'b0, count_reg};
    assign changed   = (count_next != count_reg);
    assign eng_start = dirty_reg && !eng_busy;

    // Count update: load beats an enabled tick, otherwise hold
    always_comb begin
        count_next = count_reg;
        led_next   = 1'b0;
        if (load) begin
            count_next = ({1'b0, load_value} >= m_val) ? '0 : load_value;
        end else if (tick && en_SW) begin
            if (dir_SW == DIR_UP) begin
                if (count_ext >= m_last) begin
                    count_next = '0;
                    led_next   = 1'b1;
                end else begin
                    count_next = count_reg + WIDTH'(1);
                end
            end else begin
                if ((count_reg == '0) || (count_ext >= m_val)) begin
                    count_next = m_last[WIDTH-1:0];
                    led_next   = 1'b1;
                end else begin
                    count_next = count_reg - WIDTH'(1);
                end
            end
        end
    end

    // Dirty/valid bookkeeping: a count change always wins over a finishing conversion
    always_comb begin
        dirty_next = dirty_reg;
        valid_next = valid_reg;
        bcd_next   = bcd_reg;
        if (eng_start) begin
            dirty_next = 1'b0;
        end
        if (eng_done) begin
            bcd_next   = eng_bcd;
            valid_next = !dirty_reg;
        end
        if (changed) begin
            dirty_next = 1'b1;
            valid_next = 1'b0;
        end
    end

    // Registered counter, flag and BCD state
    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            count_reg <= '0;
            led_reg   <= 1'b0;
            dirty_reg <= 1'b0;
            valid_reg <= 1'b1;
            bcd_reg   <= '0;
        end else begin
            count_reg <= count_next;
            led_reg   <= led_next;
            dirty_reg <= dirty_next;
            valid_reg <= valid_next;
            bcd_reg   <= bcd_next;
        end
    end

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_N   (rst_N),
        .start   (eng_start),
        .bin_in  (count_reg),
        .busy    (eng_busy),
        .done    (eng_done),
        .bcd_out (eng_bcd)
    );

    assign count      = count_reg;
    assign LED        = led_reg;
    assign number_BCD = bcd_reg;
    assign bcd_valid  = valid_reg;

endmodule

// File: tb/tb_bcd_modulo_counter.sv
// Directed bench for bcd_modulo_counter with default parameters.
module tb_bcd_modulo_counter;

    logic        clk = 1'b0;
    logic        rst_N = 1'b0;
    logic        tick = 1'b0;
    logic        en_SW = 1'b1;
    logic        modulo_SW = 1'b0;
    logic        dir_SW = 1'b0;
    logic        load = 1'b0;
    logic [9:0]  load_value = '0;
    logic [9:0]  count;
    logic        LED;
    logic [11:0] number_BCD;
    logic        bcd_valid;

    int n_checks = 0;
    int n_errors = 0;

    bcd_modulo_counter #(
        .WIDTH  (10),
        .DIGITS (3),
        .MOD_A  (15),
        .MOD_B  (115)
    ) dut (
        .clk        (clk),
        .rst_N      (rst_N),
        .tick       (tick),
        .en_SW      (en_SW),
        .modulo_SW  (modulo_SW),
        .dir_SW     (dir_SW),
        .load       (load),
        .load_value (load_value),
        .count      (count),
        .LED        (LED),
        .number_BCD (number_BCD),
        .bcd_valid  (bcd_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end else begin
            $display("check %s got=%0h want=%0h ok", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the BCD copy to become current
    task automatic wait_valid(input int max_cycles);
        int k = 0;
        while (!bcd_valid && k < max_cycles) begin
            step();
            k++;
        end
    endtask

    task automatic do_load(input logic [9:0] v);
        load_value = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    initial begin
        // 1: reset state
        repeat (3) step();
        rst_N = 1'b1;
        step();
        step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_bcd", 32'(number_BCD), 32'h000);
        check("rst_valid", 32'(bcd_valid), 32'd1);
        check("rst_led", 32'(LED), 32'd0);

        // 2: mode A up through the wrap
        tick = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            step();
            check("upA_count", 32'(count), 32'(i));
            check("upA_led", 32'(LED), 32'd0);
        end
        tick = 1'b0;
        wait_valid(24);
        check("upA_valid14", 32'(bcd_valid), 32'd1);
        check("upA_bcd14", 32'(number_BCD), 32'h014);
        do_tick();
        check("upA_wrap_count", 32'(count), 32'd0);
        check("upA_wrap_led", 32'(LED), 32'd1);
        step();
        check("upA_led_drop", 32'(LED), 32'd0);

        // 3: mode A down from 0, exact conversion latency
        wait_valid(24);
        check("dnA_pre_valid", 32'(bcd_valid), 32'd1);
        check("dnA_pre_bcd", 32'(number_BCD), 32'h000);
        dir_SW = 1'b1;
        do_tick();
        check("dnA_count", 32'(count), 32'd14);
        check("dnA_led", 32'(LED), 32'd1);
        check("dnA_valid_low", 32'(bcd_valid), 32'd0);
        step();
        check("dnA_led_drop", 32'(LED), 32'd0);
        repeat (10) step();
        check("dnA_valid_n11", 32'(bcd_valid), 32'd0);
        step();
        check("dnA_valid_n12", 32'(bcd_valid), 32'd1);
        check("dnA_bcd_n12", 32'(number_BCD), 32'h014);

        // 4: modulus switch, out-of-range loads, enable gating
        modulo_SW = 1'b1;
        do_load(10'd100);
        check("ld100_count", 32'(count), 32'd100);
        modulo_SW = 1'b0;
        step();
        check("swA_hold", 32'(count), 32'd100);
        dir_SW = 1'b0;
        do_tick();
        check("swA_up_count", 32'(count), 32'd0);
        check("swA_up_led", 32'(LED), 32'd1);
        modulo_SW = 1'b1;
        do_load(10'd100);
        modulo_SW = 1'b0;
        dir_SW = 1'b1;
        do_tick();
        check("swA_dn_count", 32'(count), 32'd14);
        check("swA_dn_led", 32'(LED), 32'd1);
        en_SW = 1'b0;
        do_tick();
        check("en0_hold", 32'(count), 32'd14);
        check("en0_led", 32'(LED), 32'd0);
        do_load(10'd5);
        check("en0_load", 32'(count), 32'd5);
        en_SW = 1'b1;
        dir_SW = 1'b0;
        modulo_SW = 1'b1;
        do_load(10'd123);
        check("ld123_count", 32'(count), 32'd0);
        check("ld123_led", 32'(LED), 32'd0);
        wait_valid(24);
        check("ld123_bcd", 32'(number_BCD), 32'h000);
        do_load(10'd114);
        check("ld114_count", 32'(count), 32'd114);
        repeat (11) step();
        check("ld114_valid_n11", 32'(bcd_valid), 32'd0);
        step();
        check("ld114_valid_n12", 32'(bcd_valid), 32'd1);
        check("ld114_bcd", 32'(number_BCD), 32'h114);

        // 5: tick every clock for 30 clocks from 114 in mode B
        tick = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            check("burst_valid_low", 32'(bcd_valid), 32'd0);
        end
        tick = 1'b0;
        wait_valid(24);
        check("burst_valid", 32'(bcd_valid), 32'd1);
        check("burst_count", 32'(count), 32'd29);
        check("burst_bcd", 32'(number_BCD), 32'h029);

        // 6: reset in the middle of a conversion
        do_tick();
        check("pre_rst_count", 32'(count), 32'd30);
        repeat (5) step();
        rst_N = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_led", 32'(LED), 32'd0);
        check("mid_rst_bcd", 32'(number_BCD), 32'h000);
        check("mid_rst_valid", 32'(bcd_valid), 32'd1);
        step();
        step();
        rst_N = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("post_rst_bcd", 32'(number_BCD), 32'h000);
            check("post_rst_valid", 32'(bcd_valid), 32'd1);
        end
        check("post_rst_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
